// File: rtl/wam_disp.sv
// Display driver for the whack-a-mole board: mole LEDs plus a 4-digit
// multiplexed 7-segment display with per-frame snapshots of the score and mole count.
module wam_disp #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [11:0] score,
    input  logic [7:0]  holes,
    input  logic        blank,
    output logic [7:0]  led,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [CLK_DIV-1:0] cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [11:0]        sh_score_q, sh_score_d;
    logic [3:0]         sh_cnt_q, sh_cnt_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [7:0]         led_q, led_d;

    logic       tick;
    logic [3:0] mole_cnt;
    logic [3:0] digit;
    logic       slot_blank;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        mole_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            mole_cnt = mole_cnt + {3'b000, holes[i]};
        end
    end

    always_comb begin
        tick  = &cnt_q;
        cnt_d = cnt_q + 1'b1;
        idx_d = tick ? idx_q + 2'd1 : idx_q;

        // Snapshots are taken only on the frame boundary so a frame never tears.
        sh_score_d = sh_score_q;
        sh_cnt_d   = sh_cnt_q;
        if (tick && (idx_q == 2'd3)) begin
            sh_score_d = score;
            sh_cnt_d   = mole_cnt;
        end

        digit      = 4'd0;
        slot_blank = 1'b0;
        case (idx_q)
            2'd0: digit = sh_score_q[3:0];
            2'd1: begin
                digit      = sh_score_q[7:4];
                slot_blank = (sh_score_q[11:8] == 4'd0) && (sh_score_q[7:4] == 4'd0);
            end
            2'd2: begin
                digit      = sh_score_q[11:8];
                slot_blank = (sh_score_q[11:8] == 4'd0);
            end
            default: digit = sh_cnt_q;
        endcase

        if (blank || slot_blank) begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg7(digit);
        end

        led_d = holes;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            sh_score_q <= 12'd0;
            sh_cnt_q   <= 4'd0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            led_q      <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_score_q <= sh_score_d;
            sh_cnt_q   <= sh_cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            led_q      <= led_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign led = led_q;
    assign dp  = 1'b1;

endmodule
